sd_bk_xfer: RTL and testbench

- Core-side initiator for the MiSTer block-device (sd_*) protocol.
- Moves backup data (SRAM or BMP volume) between the HPS image and SDRAM, one 512-byte sector at a time.
- Contains an internal 256x16 sector buffer and a single-word memory port into the SDRAM arbiter.
- Driven by bk_load/bk_save pulses; reports bk_loading/bk_saving to top level. One instance per volume.

---
 rtl/sd_bk_xfer_if.sv | 52 +++++
 rtl/sd_bk_xfer.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_bk_xfer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_bk_xfer_if.sv
// Block-device (sd_*) and SDRAM word-port bundle for sd_bk_xfer.
// master = the transfer engine, slave = the HPS / SDRAM arbiter side.
interface sd_bk_xfer_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic        mem_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack,
        input  sd_buff_addr,
        input  sd_buff_dout,
        input  sd_buff_wr,
        output sd_buff_din,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_dout,
        input  mem_din,
        input  mem_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack,
        output sd_buff_addr,
        output sd_buff_dout,
        output sd_buff_wr,
        input  sd_buff_din,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_dout,
        output mem_din,
        output mem_ack
    );
endinterface

// File: rtl/sd_bk_xfer.sv
// Sector-at-a-time backup mover between HPS image and SDRAM.
// Optional ack timeout/abort is enabled with `define SD_TIMEOUT_EN.
module sd_bk_xfer #(
    parameter logic [24:0] BASE_A      = 25'h0,
    parameter int          MAX_SECTORS = 256,
    parameter logic [23:0] TIMEOUT     = 24'd1000000
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         img_mounted,
    input  logic [63:0]  img_size,
    input  logic         bk_load,
    input  logic         bk_save,
    output logic         bk_ena,
    output logic         bk_loading,
    output logic         bk_saving,
    output logic         bk_error,
    sd_bk_xfer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_XFER,
        LD_COPY,
        SV_COPY,
        SV_REQ,
        SV_XFER,
        DONE
    } state_t;

    localparam logic [55:0] MAX_S = 56'(MAX_SECTORS);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] lba_q;
    logic [7:0]  w_q;
    logic [16:0] nsect_q;
    logic [16:0] nsect_new;
    logic [15:0] din_q;
    logic [15:0] buf_q [256];

    logic [55:0] sect_raw;
    logic [16:0] lba_inc;
    logic [24:0] addr_sum;
    logic        word_last;
    logic        sect_last;
    logic        start;
    logic        tmo;
    logic        copy_st;
    logic        req_st;
    logic        sv_io;
    logic        buf_we;
    logic [7:0]  buf_wa;
    logic [15:0] buf_wd;

    // ceil(size/512) kept one bit wider so an all-ones size cannot wrap
    assign sect_raw  = {1'b0, img_size[63:9]}
                     + {55'd0, |img_size[8:0]};
    assign nsect_new = (sect_raw > MAX_S) ? MAX_S[16:0]
                                          : sect_raw[16:0];

    assign bk_ena    = (nsect_q != 17'd0);
    assign start     = (state_q == IDLE) && bk_ena
                     && (bk_load || bk_save);
    assign lba_inc   = {1'b0, lba_q} + 17'd1;
    assign sect_last = (lba_inc == nsect_q);
    assign word_last = bus.mem_ack && (w_q == 8'hFF);

    assign copy_st = (state_q == LD_COPY) || (state_q == SV_COPY);
    assign req_st  = (state_q == LD_REQ)  || (state_q == SV_REQ);
    assign sv_io   = (state_q == SV_REQ)  || (state_q == SV_XFER);

    assign addr_sum = BASE_A
                    + {lba_q, 9'd0}
                    + {16'd0, w_q, 1'b0};

    assign bus.sd_lba      = {16'd0, lba_q};
    assign bus.sd_buff_din = din_q;
    assign bus.mem_addr    = copy_st ? {addr_sum[24:1], 1'b0}
                                     : 25'd0;
    assign bus.mem_dout    = bus.mem_we ? buf_q[w_q] : 16'd0;

`ifdef SD_TIMEOUT_EN
    logic [23:0] cnt_q;
    logic        err_q;

    assign tmo = req_st && !bus.sd_ack
              && (cnt_q == TIMEOUT - 24'd1);
    assign bk_error = err_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= 24'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= req_st ? cnt_q + 24'd1 : 24'd0;
            if (start)
                err_q <= 1'b0;
            else if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT;
    assign tmo        = 1'b0;
    assign bk_error   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus.sd_rd   = 1'b0;
        bus.sd_wr   = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bk_loading  = 1'b0;
        bk_saving   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bk_ena && bk_load)
                    state_d = LD_REQ;
                else if (bk_ena && bk_save)
                    state_d = SV_COPY;
            end
            LD_REQ: begin
                bk_loading = 1'b1;
                bus.sd_rd  = 1'b1;
                if (bus.sd_ack)
                    state_d = LD_XFER;
                else if (tmo)
                    state_d = DONE;
            end
            LD_XFER: begin
                bk_loading = 1'b1;
                if (!bus.sd_ack)
                    state_d = LD_COPY;
            end
            LD_COPY: begin
                bk_loading  = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (word_last)
                    state_d = sect_last ? DONE : LD_REQ;
            end
            SV_COPY: begin
                bk_saving   = 1'b1;
                bus.mem_req = 1'b1;
                if (word_last)
                    state_d = SV_REQ;
            end
            SV_REQ: begin
                bk_saving = 1'b1;
                bus.sd_wr = 1'b1;
                if (bus.sd_ack)
                    state_d = SV_XFER;
                else if (tmo)
                    state_d = DONE;
            end
            SV_XFER: begin
                bk_saving = 1'b1;
                if (!bus.sd_ack)
                    state_d = sect_last ? DONE : SV_COPY;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // single write port: HPS fills it on load, SDRAM fills it on save
    always_comb begin
        buf_we = 1'b0;
        buf_wa = bus.sd_buff_addr;
        buf_wd = bus.sd_buff_dout;
        if (((state_q == LD_REQ) || (state_q == LD_XFER))
            && bus.sd_buff_wr) begin
            buf_we = 1'b1;
        end else if ((state_q == SV_COPY) && bus.mem_ack) begin
            buf_we = 1'b1;
            buf_wa = w_q;
            buf_wd = bus.mem_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (buf_we)
            buf_q[buf_wa] <= buf_wd;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lba_q   <= 16'd0;
            w_q     <= 8'd0;
            nsect_q <= 17'd0;
            din_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && img_mounted)
                nsect_q <= nsect_new;
            if (start)
                lba_q <= 16'd0;
            else if (((state_q == LD_COPY) && word_last)
                     || ((state_q == SV_XFER) && !bus.sd_ack))
                lba_q <= lba_inc[15:0];
            if (!copy_st)
                w_q <= 8'd0;
            else if (bus.mem_ack)
                w_q <= w_q + 8'd1;
            if (sv_io)
                din_q <= buf_q[bus.sd_buff_addr];
        end
    end

endmodule

// File: tb/tb_sd_bk_xfer.sv
// Bench for sd_bk_xfer: HPS image model, SDRAM model, directed scenarios.
// Build with +define+SD_TIMEOUT_EN to also exercise the ack timeout.
module tb_sd_bk_xfer;

    localparam logic [24:0] BASE = 25'h0004000;
    localparam int          MAXS = 4;
    localparam int          TMO  = 50;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        bk_ena;
    logic        bk_loading;
    logic        bk_saving;
    logic        bk_error;

    sd_bk_xfer_if bus();

    sd_bk_xfer #(
        .BASE_A     (BASE),
        .MAX_SECTORS(MAXS),
        .TIMEOUT    (24'(TMO))
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .img_mounted(img_mounted),
        .img_size   (img_size),
        .bk_load    (bk_load),
        .bk_save    (bk_save),
        .bk_ena     (bk_ena),
        .bk_loading (bk_loading),
        .bk_saving  (bk_saving),
        .bk_error   (bk_error),
        .bus        (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [15:0] img_w [4096];
    logic [63:0] img_bytes = 64'd0;
    bit          hps_mute = 1'b0;
    logic [15:0] sdram [int];

    int          rd_lbas [$];
    int          wr_lbas [$];
    int          lba_bad = 0;
    logic [15:0] sv_data [int];
    int          wlog_a [$];
    logic [15:0] wlog_d [$];
    int          rlog_a [$];

    int   req_cyc = 0;
    int   rd_hi = 0;
    int   wr_hi = 0;
    int   sv_hi = 0;
    int   ld_fall = 0;
    logic ld_prev = 1'b0;

    function automatic logic [15:0] file_word(int i);
        if (i >= 4096 || 64'(i) * 2 >= img_bytes)
            return 16'h0000;
        return img_w[i];
    endfunction

    function automatic logic [15:0] sd_get(int k);
        if (sdram.exists(k))
            return sdram[k];
        return 16'hBAD0;
    endfunction

    function automatic logic [15:0] sv_get(int k);
        if (sv_data.exists(k))
            return sv_data[k];
        return 16'hDEAD;
    endfunction

    function automatic int exp_addr(int word);
        return (int'(BASE) + 2 * word) % (1 << 25);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (bus.mem_req) req_cyc++;
        if (bus.sd_rd) rd_hi++;
        if (bus.sd_wr) wr_hi++;
        if (bk_saving) sv_hi++;
        if (ld_prev && !bk_loading) ld_fall++;
        ld_prev = bk_loading;
    end

    // HPS side: answers sector requests from the image / into sv_data
    initial begin : hps
        int  l;
        bit  is_rd;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;
        bus.sd_buff_addr = 8'd0;
        bus.sd_buff_dout = 16'd0;
        forever begin
            @(posedge clk_sys); #1;
            if (!reset && !hps_mute && (bus.sd_rd || bus.sd_wr)) begin
                is_rd = bus.sd_rd;
                l = int'(bus.sd_lba);
                if (is_rd) rd_lbas.push_back(l);
                else wr_lbas.push_back(l);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk_sys); #1;
                end
                bus.sd_ack = 1'b1;
                for (int a = 0; a < 257; a++) begin
                    @(posedge clk_sys); #1;
                    if (bus.sd_lba !== 32'(l)) lba_bad++;
                    if (!is_rd && a > 0)
                        sv_data[l * 256 + a - 1] = bus.sd_buff_din;
                    if (a < 256) begin
                        bus.sd_buff_addr = 8'(a);
                        bus.sd_buff_dout = file_word(l * 256 + a);
                        bus.sd_buff_wr   = is_rd;
                    end
                end
                bus.sd_buff_wr = 1'b0;
                bus.sd_ack = 1'b0;
            end
        end
    end

    // SDRAM side: variable latency, one-cycle ack
    initial begin : sdr
        bus.mem_ack = 1'b0;
        bus.mem_din = 16'd0;
        forever begin
            @(posedge clk_sys); #1;
            if (bus.mem_req) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk_sys); #1;
                end
                if (bus.mem_req) begin
                    if (bus.mem_we) begin
                        wlog_a.push_back(int'(bus.mem_addr));
                        wlog_d.push_back(bus.mem_dout);
                    end else begin
                        rlog_a.push_back(int'(bus.mem_addr));
                        bus.mem_din = sd_get(int'(bus.mem_addr) >> 1);
                    end
                    bus.mem_ack = 1'b1;
                    @(posedge clk_sys); #1;
                    bus.mem_ack = 1'b0;
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(logic [63:0] sz);
        for (int i = 0; i < 4096; i++) img_w[i] = 16'($urandom);
        img_bytes = sz;
        @(posedge clk_sys); #1;
        img_size = sz;
        img_mounted = 1'b1;
        @(posedge clk_sys); #1;
        img_mounted = 1'b0;
    endtask

    task automatic start(bit ld, bit sv);
        @(posedge clk_sys); #1;
        bk_load = ld;
        bk_save = sv;
        @(posedge clk_sys); #1;
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while ((bk_loading || bk_saving) && n < 20000) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk({tag, ".finish"}, 64'(n < 20000), 64'd1);
        cyc(2);
    endtask

    task automatic run_load(string tag, int nexp, bit both, bit mid);
        int rb = rd_lbas.size();
        int wb = wlog_a.size();
        int rn = rlog_a.size();
        int wh = wr_hi;
        int sh = sv_hi;
        int lf = ld_fall;
        int lb = lba_bad;
        int bad_a = 0;
        int bad_d = 0;
        start(1'b1, both);
        chk({tag, ".loading"}, 64'(bk_loading), 64'd1);
        if (mid) begin
            @(posedge clk_sys); #1;
            img_size = 64'd0;
            img_mounted = 1'b1;
            @(posedge clk_sys); #1;
            img_mounted = 1'b0;
            img_size = img_bytes;
        end
        wait_idle(tag);
        chk({tag, ".nsect"}, 64'(rd_lbas.size() - rb), 64'(nexp));
        for (int k = 0; k < nexp; k++)
            chk({tag, ".lba"},
                64'((rb + k < rd_lbas.size()) ? rd_lbas[rb + k] : -1),
                64'(k));
        chk({tag, ".nwr"}, 64'(wlog_a.size() - wb), 64'(nexp * 256));
        for (int i = 0; i < nexp * 256; i++) begin
            if (wb + i >= wlog_a.size()) break;
            if (wlog_a[wb + i] != exp_addr(i)) bad_a++;
            if (wlog_d[wb + i] !== file_word(i)) bad_d++;
        end
        chk({tag, ".waddr_bad"}, 64'(bad_a), 64'd0);
        chk({tag, ".wdata_bad"}, 64'(bad_d), 64'd0);
        chk({tag, ".no_rd"}, 64'(rlog_a.size() - rn), 64'd0);
        chk({tag, ".no_sdwr"}, 64'(wr_hi - wh), 64'd0);
        chk({tag, ".no_saving"}, 64'(sv_hi - sh), 64'd0);
        chk({tag, ".ld_fall"}, 64'(ld_fall - lf), 64'd1);
        chk({tag, ".lba_stable"}, 64'(lba_bad - lb), 64'd0);
        chk({tag, ".ena"}, 64'(bk_ena), 64'd1);
    endtask

    task automatic run_save(string tag, int nexp);
        int wb = wr_lbas.size();
        int mw = wlog_a.size();
        int rn = rlog_a.size();
        int rh = rd_hi;
        int lb = lba_bad;
        int bad_a = 0;
        int bad_d = 0;
        start(1'b0, 1'b1);
        chk({tag, ".saving"}, 64'(bk_saving), 64'd1);
        wait_idle(tag);
        chk({tag, ".nsect"}, 64'(wr_lbas.size() - wb), 64'(nexp));
        for (int k = 0; k < nexp; k++)
            chk({tag, ".lba"},
                64'((wb + k < wr_lbas.size()) ? wr_lbas[wb + k] : -1),
                64'(k));
        chk({tag, ".nrd"}, 64'(rlog_a.size() - rn), 64'(nexp * 256));
        for (int i = 0; i < nexp * 256; i++) begin
            if (rn + i < rlog_a.size() && rlog_a[rn + i] != exp_addr(i))
                bad_a++;
            if (sv_get(i) !== sd_get((int'(BASE) >> 1) + i)) bad_d++;
        end
        chk({tag, ".raddr_bad"}, 64'(bad_a), 64'd0);
        chk({tag, ".din_bad"}, 64'(bad_d), 64'd0);
        chk({tag, ".no_memwr"}, 64'(wlog_a.size() - mw), 64'd0);
        chk({tag, ".no_sdrd"}, 64'(rd_hi - rh), 64'd0);
        chk({tag, ".lba_stable"}, 64'(lba_bad - lb), 64'd0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".flags"},
            64'({bk_ena, bk_loading, bk_saving, bk_error,
                 bus.sd_rd, bus.sd_wr, bus.mem_req, bus.mem_we}),
            64'd0);
        chk({tag, ".data"},
            {bus.sd_lba, bus.sd_buff_din, bus.mem_dout}, 64'd0);
        chk({tag, ".addr"}, 64'(bus.mem_addr), 64'd0);
    endtask

    initial begin : main
        int wb;
        int n;
        int rq;
        int wh;
        int rh;
        int sh;

        #12;
        chk_zero("reset");
        @(posedge clk_sys); #1;
        reset = 1'b0;
        cyc(2);
        chk_zero("post_reset");

        mount(64'd1024);
        chk("ena_1024", 64'(bk_ena), 64'd1);
        run_load("ld1024", 2, 1'b0, 1'b1);

        mount(64'd600);
        run_load("ld600", 2, 1'b0, 1'b0);

        mount(64'd5000);
        run_load("ldcap", MAXS, 1'b0, 1'b0);

        mount(64'hFFFF_FFFF_FFFF_FFFF);
        chk("ena_huge", 64'(bk_ena), 64'd1);

        mount(64'd512);
        for (int i = 0; i < 256; i++)
            sdram[(int'(BASE) >> 1) + i] = 16'h1000 + 16'(i);
        run_save("sv1", 1);
        chk("sv1.first", 64'(sv_get(0)), 64'h1000);
        chk("sv1.last", 64'(sv_get(255)), 64'h10FF);

        mount(64'd1500);
        for (int i = 0; i < 768; i++)
            sdram[(int'(BASE) >> 1) + i] = 16'($urandom);
        run_save("sv3", 3);

        mount(64'd1024);
        run_load("both", 2, 1'b1, 1'b0);

        mount(64'd0);
        chk("ena_zero", 64'(bk_ena), 64'd0);
        rq = req_cyc;
        wh = wr_hi;
        rh = rd_hi;
        sh = sv_hi;
        start(1'b0, 1'b1);
        start(1'b1, 1'b0);
        cyc(20);
        chk("zero.no_req", 64'(req_cyc - rq), 64'd0);
        chk("zero.no_sdwr", 64'(wr_hi - wh), 64'd0);
        chk("zero.no_sdrd", 64'(rd_hi - rh), 64'd0);
        chk("zero.no_saving", 64'(sv_hi - sh), 64'd0);

        mount(64'd1024);
        wb = wlog_a.size();
        start(1'b1, 1'b0);
        n = 0;
        while (wlog_a.size() - wb < 100 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("rst.reach_w100", 64'(n < 5000), 64'd1);
        @(posedge clk_sys); #1;
        chk("rst.in_copy", 64'({bus.mem_req, bus.mem_we}), 64'd3);
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        chk("rst.nwr", 64'(wlog_a.size() - wb), 64'd100);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        wb = wlog_a.size();
        rq = req_cyc;
        cyc(30);
        chk("rst.no_more_wr", 64'(wlog_a.size() - wb), 64'd0);
        chk("rst.no_more_req", 64'(req_cyc - rq), 64'd0);
        chk("rst.ena", 64'(bk_ena), 64'd0);
        mount(64'd1024);
        run_load("rst_restart", 2, 1'b0, 1'b0);

`ifdef SD_TIMEOUT_EN
        mount(64'd512);
        hps_mute = 1'b1;
        rh = rd_hi;
        start(1'b1, 1'b0);
        wait_idle("tmo");
        chk("tmo.rd_cycles", 64'(rd_hi - rh), 64'(TMO));
        chk("tmo.error", 64'(bk_error), 64'd1);
        chk("tmo.loading", 64'(bk_loading), 64'd0);
        hps_mute = 1'b0;
        run_load("after_tmo", 1, 1'b0, 1'b0);
`endif
        chk("error_clear", 64'(bk_error), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
